regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter_pkg.sv | 14 +
 rtl/regfile_arbiter_rr_arb2.sv | 27 ++
 rtl/regfile_arbiter.sv | 169 ++++++++++++++++
 tb/tb_regfile_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arbiter_pkg.sv
// Shared types and defaults for the card regfile arbiter.
// Widths default here; FSM encoding for the read side.
package regfile_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    SINGLE = 2'd2
  } rd_state_e;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-port round-robin arbiter, combinational grant.
// After reset the turn favours port A.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic last_b;

  assign gnt_a = req_a & (~req_b | last_b);
  assign gnt_b = req_b & ~gnt_a;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_b <= 1'b1;
    end else if (gnt_a) begin
      last_b <= 1'b0;
    end else if (gnt_b) begin
      last_b <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Card regfile arbiter: 2 write ports, display sweep, hit-test read.
// Define REGFILE_ARBITER_BYPASS_EN to forward a colliding write to sr_rdata.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   num_of_cards,
  input  logic              wa_valid,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  output logic              wa_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_valid,
  input  logic              sr_valid,
  input  logic [ADDR_W-1:0] sr_addr,
  output logic              sr_ready,
  output logic              sr_rdata_valid,
  output logic [DATA_W-1:0] sr_rdata,
  input  logic [DATA_W-1:0] rf_r_data,
  output logic              rf_w_en,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic [ADDR_W-1:0] rf_r_addr
);

  logic              gnt_a;
  logic              gnt_b;
  logic              w_gnt;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_in_range;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_a (wa_valid & rst),
    .req_b (wb_valid & rst),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  assign wa_ready = gnt_a;
  assign wb_ready = gnt_b;
  assign w_gnt    = gnt_a | gnt_b;

  always_comb begin
    w_addr = wa_addr;
    w_data = wa_data;
    if (gnt_b) begin
      w_addr = wb_addr;
      w_data = wb_data;
    end
  end

  // Out-of-range writes are still acknowledged, just not committed.
  assign w_in_range = {1'b0, w_addr} < num_of_cards;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_w_en   <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
    end else begin
      rf_w_en <= w_gnt & w_in_range;
      if (w_gnt) begin
        rf_w_addr <= w_addr;
        rf_w_data <= w_data;
      end
    end
  end

  rd_state_e       state;
  rd_state_e       state_nxt;
  logic [ADDR_W:0] n_q;
  logic            sweep_last;
  logic            sr_accept;
  logic [DATA_W-1:0] rd_data;

  assign sweep_last =
    (n_q == '0) |
    (({1'b0, rf_r_addr} + (ADDR_W+1)'(1)) == n_q);
  assign sr_accept = sr_valid & sr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (sweep_start) begin
          state_nxt = SWEEP;
        end else if (sr_accept) begin
          state_nxt = SINGLE;
        end
      end
      SWEEP: begin
        if (sweep_last) begin
          state_nxt = IDLE;
        end
      end
      SINGLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sweep_busy = (state == SWEEP);
    sr_ready   = rst & (state == IDLE) & ~sweep_start;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q            <= '0;
      rf_r_addr      <= '0;
      sweep_valid    <= 1'b0;
      sr_rdata_valid <= 1'b0;
    end else begin
      sweep_valid    <= (state == SWEEP) && (n_q != '0);
      sr_rdata_valid <= (state == SINGLE);
      if (state == IDLE && sweep_start) begin
        n_q       <= num_of_cards;
        rf_r_addr <= '0;
      end else if (state == IDLE && sr_accept) begin
        rf_r_addr <= sr_addr;
      end else if (state == SWEEP && !sweep_last) begin
        rf_r_addr <= rf_r_addr + ADDR_W'(1);
      end
    end
  end

`ifdef REGFILE_ARBITER_BYPASS_EN
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;

  // Regfile is read-first, so a same-cycle write would be missed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit  <= (state == SINGLE) & rf_w_en &
                  (rf_w_addr == rf_r_addr);
      byp_data <= rf_w_data;
    end
  end

  assign rd_data = byp_hit ? byp_data : rf_r_data;
`else
  assign rd_data = rf_r_data;
`endif

  assign sr_rdata = sr_rdata_valid ? rd_data : '0;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized bench for regfile_arbiter with a card-memory model.
// Honours REGFILE_ARBITER_BYPASS_EN for the collision case.
module tb_regfile_arbiter;

  localparam int AW = 5;
  localparam int DW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW:0]   num_of_cards;
  logic          wa_valid, wb_valid;
  logic [AW-1:0] wa_addr, wb_addr;
  logic [DW-1:0] wa_data, wb_data;
  logic          wa_ready, wb_ready;
  logic          sweep_start, sweep_busy, sweep_valid;
  logic          sr_valid, sr_ready, sr_rdata_valid;
  logic [AW-1:0] sr_addr;
  logic [DW-1:0] sr_rdata;
  logic [DW-1:0] rf_r_data;
  logic          rf_w_en;
  logic [AW-1:0] rf_w_addr;
  logic [DW-1:0] rf_w_data;
  logic [AW-1:0] rf_r_addr;

  always #5 clk = ~clk;

  regfile_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .num_of_cards   (num_of_cards),
    .wa_valid       (wa_valid),
    .wa_addr        (wa_addr),
    .wa_data        (wa_data),
    .wa_ready       (wa_ready),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .wb_ready       (wb_ready),
    .sweep_start    (sweep_start),
    .sweep_busy     (sweep_busy),
    .sweep_valid    (sweep_valid),
    .sr_valid       (sr_valid),
    .sr_addr        (sr_addr),
    .sr_ready       (sr_ready),
    .sr_rdata_valid (sr_rdata_valid),
    .sr_rdata       (sr_rdata),
    .rf_r_data      (rf_r_data),
    .rf_w_en        (rf_w_en),
    .rf_w_addr      (rf_w_addr),
    .rf_w_data      (rf_w_data),
    .rf_r_addr      (rf_r_addr)
  );

  // Read-first card memory with 1-cycle read latency.
  logic [DW-1:0] rf_mem [32];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_r_data <= '0;
      for (int i = 0; i < 32; i++) rf_mem[i] <= DW'(i * 5 + 3);
    end else begin
      rf_r_data <= rf_mem[rf_r_addr];
      if (rf_w_en) rf_mem[rf_w_addr] <= rf_w_data;
    end
  end

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] mem_ref [32];
  bit            last_b;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 32; i++) mem_ref[i] = DW'(i * 5 + 3);
    last_b = 1'b1;
  endtask

  task automatic idle_inputs();
    wa_valid    = 1'b0;
    wb_valid    = 1'b0;
    sr_valid    = 1'b0;
    sweep_start = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({wa_ready, wb_ready, sweep_busy, sweep_valid,
                sr_ready, sr_rdata_valid, sr_rdata, rf_w_en,
                rf_w_addr, rf_w_data, rf_r_addr});
  endfunction

  task automatic wr_cycle(input bit va, input logic [AW-1:0] aa,
                          input logic [DW-1:0] da,
                          input bit vb, input logic [AW-1:0] ab,
                          input logic [DW-1:0] db);
    bit ga, gb, en;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    wa_valid = va; wa_addr = aa; wa_data = da;
    wb_valid = vb; wb_addr = ab; wb_data = db;
    // Contention goes to whoever did not win last time.
    if (va && vb) begin
      ga = last_b;
      gb = !last_b;
    end else begin
      ga = va;
      gb = vb;
    end
    @(negedge clk);
    check("wa_ready", 32'(wa_ready), 32'(ga));
    check("wb_ready", 32'(wb_ready), 32'(gb));
    en = 1'b0;
    ea = ga ? aa : ab;
    ed = ga ? da : db;
    if (ga || gb) begin
      last_b = gb;
      en = (int'(ea) < int'(num_of_cards));
      if (en) mem_ref[ea] = ed;
    end
    tick();
    check("rf_w_en", 32'(rf_w_en), 32'(en));
    if (en) begin
      check("rf_w_addr", 32'(rf_w_addr), 32'(ea));
      check("rf_w_data", 32'(rf_w_data), 32'(ed));
    end
  endtask

  task automatic sweep_run(input int n, input bit restart);
    int busy = 0;
    int vc = 0;
    num_of_cards = (AW+1)'(n);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int c = 0; c < n + 6; c++) begin
      if (restart) sweep_start = (c == 3);
      if (sweep_busy) begin
        if (n > 0) check("sweep_addr", 32'(rf_r_addr), 32'(busy));
        busy++;
      end
      if (sweep_valid) begin
        if (vc < 32)
          check("sweep_data", 32'(rf_r_data), 32'(mem_ref[vc]));
        vc++;
      end
      tick();
    end
    sweep_start = 1'b0;
    check("sweep_busy_cycles", 32'(busy), 32'((n == 0) ? 1 : n));
    check("sweep_valid_count", 32'(vc), 32'(n));
  endtask

  task automatic sr_run(input logic [AW-1:0] a);
    sr_valid = 1'b1;
    sr_addr  = a;
    @(negedge clk);
    check("sr_ready", 32'(sr_ready), 32'd1);
    tick();
    sr_valid = 1'b0;
    check("sr_early", 32'(sr_rdata_valid), 32'd0);
    tick();
    check("sr_rdata_valid", 32'(sr_rdata_valid), 32'd1);
    check("sr_rdata", 32'(sr_rdata), 32'(mem_ref[a]));
    tick();
    check("sr_valid_pulse", 32'(sr_rdata_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_k;
    int seen;
    bit accepted;
    logic [DW-1:0] exp_d;
    idle_inputs();
    num_of_cards = 6'd16;
    wa_addr = '0; wa_data = '0;
    wb_addr = '0; wb_data = '0;
    sr_addr = '0;
    ref_reset();
    repeat (3) tick();
    check("reset_outputs", all_outputs(), 32'd0);
    rst = 1'b1;
    tick();

    // Out-of-range write is acked but not committed.
    wr_cycle(1'b1, 5'd20, 7'h11, 1'b0, 5'd0, 7'h0);
    idle_inputs();
    tick();

    // Both ports contend after A was granted last.
    for (int i = 0; i < 4; i++) begin
      wa_valid = 1'b1; wa_addr = 5'd1; wa_data = DW'(8'h40 + i);
      wb_valid = 1'b1; wb_addr = 5'd2; wb_data = DW'(8'h60 + i);
      @(negedge clk);
      check("rr_grant_a", 32'(wa_ready), 32'(i % 2));
      check("rr_grant_b", 32'(wb_ready), 32'((i + 1) % 2));
      if (i % 2 == 0) mem_ref[2] = wb_data;
      else            mem_ref[1] = wa_data;
      last_b = (i % 2 == 0);
      tick();
      check("rr_w_en", 32'(rf_w_en), 32'd1);
      check("rr_w_addr", 32'(rf_w_addr), 32'((i % 2 == 0) ? 2 : 1));
    end
    idle_inputs();
    tick();

    for (int i = 0; i < 160; i++) begin
      if (i % 20 == 0) num_of_cards = (AW+1)'($urandom_range(0, 32));
      wr_cycle(1'($urandom), AW'($urandom), DW'($urandom),
               1'($urandom), AW'($urandom), DW'($urandom));
    end
    idle_inputs();
    tick();

    sweep_run(32, 1'b0);
    sweep_run(16, 1'b1);
    sweep_run(0, 1'b0);
    sweep_run($urandom_range(1, 31), 1'b0);

    num_of_cards = 6'd32;
    for (int i = 0; i < 12; i++) sr_run(AW'($urandom));

    // Sweep wins over a simultaneous single read.
    num_of_cards = 6'd8;
    sweep_start = 1'b1;
    sr_valid = 1'b1;
    sr_addr = 5'd9;
    accepted = 1'b0;
    acc_k = -1;
    for (int k = 0; k < 40 && !accepted; k++) begin
      @(negedge clk);
      if (sr_ready) begin
        accepted = 1'b1;
        acc_k = k;
        check("col_busy_at_accept", 32'(sweep_busy), 32'd0);
      end
      tick();
      sweep_start = 1'b0;
    end
    sr_valid = 1'b0;
    check("col_accept_cycle", 32'(acc_k), 32'd9);
    tick();
    check("col_rdata_valid", 32'(sr_rdata_valid), 32'd1);
    check("col_rdata", 32'(sr_rdata), 32'(mem_ref[9]));
    tick();

    // Write and single read hit the same card in the same cycle.
    num_of_cards = 6'd16;
    wr_cycle(1'b1, 5'd3, 7'h55, 1'b0, 5'd0, 7'h0);
    idle_inputs();
    tick();
    wa_valid = 1'b1; wa_addr = 5'd3; wa_data = 7'h2A;
    sr_valid = 1'b1; sr_addr = 5'd3;
    @(negedge clk);
    check("byp_wa_ready", 32'(wa_ready), 32'd1);
    check("byp_sr_ready", 32'(sr_ready), 32'd1);
    last_b = 1'b0;
    tick();
    idle_inputs();
    check("byp_w_en", 32'(rf_w_en), 32'd1);
    tick();
`ifdef REGFILE_ARBITER_BYPASS_EN
    exp_d = 7'h2A;
`else
    exp_d = mem_ref[3];
`endif
    check("byp_valid", 32'(sr_rdata_valid), 32'd1);
    check("byp_rdata", 32'(sr_rdata), 32'(exp_d));
    mem_ref[3] = 7'h2A;
    tick();

    // Reset in the middle of a sweep.
    num_of_cards = 6'd16;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k < 30 && rf_r_addr != 5'd5; k++) tick();
    check("reset_at_addr5", 32'(rf_r_addr), 32'd5);
    wa_valid = 1'b1; wb_valid = 1'b1; sr_valid = 1'b1;
    rst = 1'b0;
    #1;
    check("reset_mid_sweep", all_outputs(), 32'd0);
    tick();
    tick();
    idle_inputs();
    rst = 1'b1;
    ref_reset();
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (sweep_valid || sweep_busy) seen++;
      tick();
    end
    check("no_sweep_after_reset", 32'(seen), 32'd0);
    sweep_run(4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
